// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for the universal shift register.
// The master side drives mode/enable/serial/parallel inputs; the register
// (slave side) returns its contents, complement, shift count and done flag.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             En;
  logic             Sclr_N;
  logic [1:0]       S;
  logic             Dsr;
  logic             Dsl;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_N;
  logic [CW-1:0]    Cnt;
  logic             Done;

  modport master (
    output En, Sclr_N, S, Dsr, Dsl, D,
    input  Q, Q_N, Cnt, Done
  );

  modport slave (
    input  En, Sclr_N, S, Dsr, Dsl, D,
    output Q, Q_N, Cnt, Done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register in the style of a 74HC194: hold, shift right,
// shift left and parallel load, with clock enable, synchronous clear,
// optional rotate and a saturating count of shifts since the last load/clear.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               ROTATE    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              R_N,
  univ_shift_reg_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;
  logic             msb_in;
  logic             lsb_in;

  // In rotate mode the end bits wrap around and the serial inputs are unused.
  generate
    if (ROTATE != 0) begin : g_rotate
      assign msb_in = q_reg[0];
      assign lsb_in = q_reg[WIDTH-1];
    end else begin : g_serial
      assign msb_in = bus.Dsr;
      assign lsb_in = bus.Dsl;
    end
  endgenerate

  // Shift count saturates so Done stays asserted through extra shifts.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  // Next state: enable gates everything, then clear, then the mode decode.
  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (!bus.En) begin
      q_next   = q_reg;
      cnt_next = cnt_reg;
    end else if (!bus.Sclr_N) begin
      q_next   = '0;
      cnt_next = '0;
    end else begin
      case (bus.S)
        MODE_HOLD: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
        MODE_RIGHT: begin
          q_next   = {msb_in, q_reg[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_LEFT: begin
          q_next   = {q_reg[WIDTH-2:0], lsb_in};
          cnt_next = cnt_inc;
        end
        MODE_LOAD: begin
          q_next   = bus.D;
          cnt_next = '0;
        end
        default: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
      endcase
    end
  end

  // State register; reset is asynchronous so it discards any shift in progress.
  always_ff @(posedge Clk or negedge R_N) begin
    if (!R_N) begin
      q_reg   <= RESET_VAL;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      cnt_reg <= cnt_next;
    end
  end

  assign bus.Q    = q_reg;
  assign bus.Q_N  = ~q_reg;
  assign bus.Cnt  = cnt_reg;
  assign bus.Done = (cnt_reg == CNT_MAX);
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit universal register. Next generation of the team's dual D flip-flop: it goes from 2 single-bit channels to WIDTH bits with selectable modes.
- Modes: hold, shift-right, shift-left and parallel load, 74HC194-style. Adds synchronous clear, clock enable, an optional rotate mode and a shift counter with a done flag.
- Used as a serializer/deserializer and general staging register in the lab datapath designs.

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- ROTATE, 0: 1 = shifts wrap the end bit around; serial inputs are ignored.
- RESET_VAL, 0: value loaded into Q on async reset; WIDTH bits.

Ports:
- Clk  in  1  rising-edge clock.
- R_N  in  1  asynchronous active-low reset.
- En  in  1  synchronous clock enable; 0 = hold everything.
- Sclr_N  in  1  synchronous active-low clear.
- S  in  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- Dsr  in  1  serial input for shift right (enters the MSB).
- Dsl  in  1  serial input for shift left (enters the LSB).
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- Q_N  out  WIDTH  bitwise complement of Q.
- Cnt  out  clog2(WIDTH+1)  shifts since the last load/clear; saturates at WIDTH.
- Done  out  1  high when Cnt == WIDTH.

Behaviour:
- Reset: R_N low at any time, independent of Clk, forces Q=RESET_VAL, Q_N=~RESET_VAL, Cnt=0, Done=0 immediately.
  - Deassertion is sampled at the next rising Clk.
  - Reset mid-shift abandons the operation; no partial state is kept.
- All other updates happen on rising Clk. Priority:
  1. R_N.
  2. En=0: Q and Cnt hold, regardless of Sclr_N and S.
  3. Sclr_N=0: Q=0, Cnt=0.
  4. S decode.
- S=00 hold: Q and Cnt unchanged.
- S=01 shift right: Q[i] <= Q[i+1] for i<WIDTH-1. Q[WIDTH-1] <= Dsr, or Q[0] when ROTATE=1. Cnt increments, saturating at WIDTH.
- S=10 shift left: Q[i] <= Q[i-1] for i>0. Q[0] <= Dsl, or Q[WIDTH-1] when ROTATE=1. Cnt increments, saturating at WIDTH.
- S=11 load: Q <= D; Cnt <= 0.
- Serial-out points are Q[0] for right shifts and Q[WIDTH-1] for left shifts. They are read straight from Q; there is no extra port.
- Q_N is combinational from Q and is never X after reset.
- Done is combinational from Cnt. Once Cnt reaches WIDTH it stays there through further shifts until load, clear or reset.
- Alternating right and left shifts both increment Cnt; Cnt counts shift operations, not net displacement.
- Latency: one cycle from the control sample to the new Q. No pipeline, no handshake.
- Every S value is legal; there is no X-propagation path.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, pulse R_N low between clock edges -> Q=A5 and Q_N=5A immediately, Cnt=0, Done=0, no Clk edge needed.
- Load then shift right: S=11, D=8'h81; then S=01, Dsr=0 for 8 cycles -> Q=40,20,10,08,04,02,01,00; Cnt 1..8; Done=1 on the 8th edge, still 1 after a 9th shift.
- Shift left serial fill: from Q=0, S=10, Dsl=1,0,1,1 -> Q=01,02,05,0B; Cnt=4, Done=0.
- Rotate (ROTATE=1): load 8'h01, S=01 for 8 cycles -> Q=80,40,...,01 restored after 8 edges; Dsr toggling has no effect.
- Priority: En=0 with Sclr_N=0 and S=11 -> Q holds; then En=1, Sclr_N=0, S=11, D=FF -> Q=00 and Cnt=0 (clear beats load).
- Async reset mid-shift: shifting with Cnt=3, drop R_N low mid-cycle -> Q=RESET_VAL and Cnt=0 at once; first edge after release applies the current S normally.
